pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_capture_sync_edge.sv | 28 ++
 rtl/pwm_capture.sv | 115 +++++++++++
 tb/tb_pwm_capture.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair: capture FSM states and
// default counter sizing.
package pwm_pkg;

  localparam int DEFAULT_CNT_W          = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a rising-edge detector
// on the synchronized level.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign level = r_s2;
  assign rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM input between rising edges, hands the
// pair out over a valid/ready interface and flags stuck inputs and lost results.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W          = DEFAULT_CNT_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             timeout,
  output logic             stuck_level,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic             w_s2, w_rise;
  logic             w_expire, w_complete, w_xfer, w_accept;
  cap_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_per, r_high;
  logic [CNT_W-1:0] r_high_cnt, r_period_cnt;
  logic             r_valid, r_timeout, r_stuck, r_overrun;

  sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (pwm_in),
    .level (w_s2),
    .rise  (w_rise)
  );

  // The period counter saturates at TO_MAX, so expiry fires once per stuck episode.
  assign w_expire   = !w_rise && (r_per == TO_LAST);
  assign w_complete = w_rise && (r_state == MEAS_LOW);
  assign w_xfer     = r_valid && meas_ready;
  assign w_accept   = w_complete && (!r_valid || meas_ready);

  always_ff @(posedge clk) begin
    if (rst) r_state <= WAIT_RISE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_RISE: if (w_rise) w_state_nxt = MEAS_HIGH;
      MEAS_HIGH: begin
        if (w_expire)  w_state_nxt = WAIT_RISE;
        else if (!w_s2) w_state_nxt = MEAS_LOW;
      end
      MEAS_LOW: begin
        if (w_rise)        w_state_nxt = MEAS_HIGH;
        else if (w_expire) w_state_nxt = WAIT_RISE;
      end
      default: w_state_nxt = WAIT_RISE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_per  <= '0;
      r_high <= '0;
    end else if (w_rise) begin
      r_per  <= ONE;
      r_high <= ONE;
    end else begin
      if (r_per != TO_MAX) r_per <= r_per + ONE;
      if (w_s2 && (r_state != WAIT_RISE) && (r_per != TO_MAX)) r_high <= r_high + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
      r_stuck      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_high_cnt   <= r_high;
        r_period_cnt <= r_per;
        r_valid      <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end

      // A completion that lands on a transfer replaces the pair, so nothing is lost.
      if (w_complete && r_valid && !meas_ready) r_overrun <= 1'b1;
      else if (w_xfer && !w_complete)           r_overrun <= 1'b0;

      if (w_rise)        r_timeout <= 1'b0;
      else if (w_expire) r_timeout <= 1'b1;

      if (!w_rise && (w_expire || r_timeout)) r_stuck <= w_s2;
    end
  end

  assign high_cnt    = r_high_cnt;
  assign period_cnt  = r_period_cnt;
  assign meas_valid  = r_valid;
  assign timeout     = r_timeout;
  assign stuck_level = r_stuck;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: waveform patterns are generated per cycle and
// outputs are compared against hand-derived values at chosen cycle indices.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic [15:0] high_cnt;
  logic [15:0] period_cnt;
  logic        meas_valid;
  logic        meas_ready;
  logic        timeout;
  logic        stuck_level;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_capture #(.CNT_W(16), .TIMEOUT_CYCLES(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .high_cnt    (high_cnt),
    .period_cnt  (period_cnt),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .timeout     (timeout),
    .stuck_level (stuck_level),
    .overrun     (overrun)
  );

  // Loop iteration i samples the state after posedge i-1 and drives inputs for posedge i.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pwm_in = 1'b0; meas_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", meas_valid); end
    n_vec++; if (high_cnt !== 16'd0) begin n_err++; $display("FAIL rst_high: got %0d want 0", high_cnt); end
    n_vec++; if (period_cnt !== 16'd0) begin n_err++; $display("FAIL rst_period: got %0d want 0", period_cnt); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    n_vec++; if (stuck_level !== 1'b0) begin n_err++; $display("FAIL rst_stuck: got %b want 0", stuck_level); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_pwm_64_256();
    int pulses = 0;
    int first  = -1;
    int dbl    = 0;
    logic prev = 1'b0;
    do_reset();
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (meas_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        if (prev) dbl++;
        n_vec++; if (high_cnt !== 16'd64) begin n_err++; $display("FAIL pwm64_high@%0d: got %0d want 64", i, high_cnt); end
        n_vec++; if (period_cnt !== 16'd256) begin n_err++; $display("FAIL pwm64_period@%0d: got %0d want 256", i, period_cnt); end
      end
      prev = meas_valid;
      pwm_in = (i < 1280) && ((i % 256) < 64);
      meas_ready = 1'b1;
    end
    n_vec++; if (pulses != 4) begin n_err++; $display("FAIL pwm64_pulses: got %0d want 4", pulses); end
    n_vec++; if (first != 259) begin n_err++; $display("FAIL pwm64_first: got %0d want 259", first); end
    n_vec++; if (dbl != 0) begin n_err++; $display("FAIL pwm64_width: got %0d multi-cycle pulses want 0", dbl); end
  endtask

  task automatic test_narrow_pulse();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (meas_valid === 1'b1) begin
        pulses++;
        n_vec++; if (high_cnt !== 16'd1) begin n_err++; $display("FAIL narrow_high@%0d: got %0d want 1", i, high_cnt); end
        n_vec++; if (period_cnt !== 16'd10) begin n_err++; $display("FAIL narrow_period@%0d: got %0d want 10", i, period_cnt); end
      end
      pwm_in = (i < 50) && ((i % 10) == 0);
      meas_ready = 1'b1;
    end
    n_vec++; if (pulses != 4) begin n_err++; $display("FAIL narrow_pulses: got %0d want 4", pulses); end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 480; i++) begin
      @(negedge clk);
      if (i == 300) begin
        n_vec++; if (meas_valid !== 1'b1) begin n_err++; $display("FAIL ovr_first_valid: got %b want 1", meas_valid); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_before: got %b want 0", overrun); end
      end
      if (i == 470) begin
        n_vec++; if (meas_valid !== 1'b1) begin n_err++; $display("FAIL ovr_held_valid: got %b want 1", meas_valid); end
        n_vec++; if (high_cnt !== 16'd64) begin n_err++; $display("FAIL ovr_held_high: got %0d want 64", high_cnt); end
        n_vec++; if (period_cnt !== 16'd256) begin n_err++; $display("FAIL ovr_held_period: got %0d want 256", period_cnt); end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", overrun); end
      end
      if (i == 476 || i == 479) begin
        n_vec++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL ovr_xfer_valid@%0d: got %b want 0", i, meas_valid); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear@%0d: got %b want 0", i, overrun); end
      end
      pwm_in = (i < 64) || (i >= 256 && i < 286) || (i >= 456 && i < 460);
      meas_ready = (i == 475);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 1390; i++) begin
      @(negedge clk);
      if (i == 1020) begin
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL to_early: got %b want 0", timeout); end
      end
      if (i == 1030) begin
        n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL to_set: got %b want 1", timeout); end
        n_vec++; if (stuck_level !== 1'b1) begin n_err++; $display("FAIL to_stuck_hi: got %b want 1", stuck_level); end
        n_vec++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL to_no_pair: got %b want 0", meas_valid); end
      end
      if (i == 1118) begin
        n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL to_hold: got %b want 1", timeout); end
        n_vec++; if (stuck_level !== 1'b0) begin n_err++; $display("FAIL to_stuck_lo: got %b want 0", stuck_level); end
      end
      if (i == 1130) begin
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b want 0", timeout); end
      end
      if (i == 1385) begin
        n_vec++; if (meas_valid !== 1'b1) begin n_err++; $display("FAIL to_after_valid: got %b want 1", meas_valid); end
        n_vec++; if (high_cnt !== 16'd64) begin n_err++; $display("FAIL to_after_high: got %0d want 64", high_cnt); end
        n_vec++; if (period_cnt !== 16'd256) begin n_err++; $display("FAIL to_after_period: got %0d want 256", period_cnt); end
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL to_after_timeout: got %b want 0", timeout); end
      end
      pwm_in = (i < 1100) || (i >= 1120 && i < 1184) || (i >= 1376 && i < 1386);
      meas_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic saw = 1'b0;
    do_reset();
    for (int i = 0; i < 780; i++) begin
      @(negedge clk);
      if (i == 356) begin
        n_vec++; if (meas_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pending: got %b want 1", meas_valid); end
      end
      if (i == 357) begin
        n_vec++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", meas_valid); end
        n_vec++; if (high_cnt !== 16'd0) begin n_err++; $display("FAIL rmid_high: got %0d want 0", high_cnt); end
        n_vec++; if (period_cnt !== 16'd0) begin n_err++; $display("FAIL rmid_period: got %0d want 0", period_cnt); end
        n_vec++; if ({timeout, stuck_level, overrun} !== 3'b000) begin n_err++; $display("FAIL rmid_flags: got %b want 000", {timeout, stuck_level, overrun}); end
      end
      if (i >= 357 && i <= 770 && meas_valid !== 1'b0) saw = 1'b1;
      if (i == 778) begin
        n_vec++; if (saw !== 1'b0) begin n_err++; $display("FAIL rmid_early_valid: got %b want 0", saw); end
        n_vec++; if (meas_valid !== 1'b1) begin n_err++; $display("FAIL rmid_after_valid: got %b want 1", meas_valid); end
        n_vec++; if (high_cnt !== 16'd64) begin n_err++; $display("FAIL rmid_after_high: got %0d want 64", high_cnt); end
        n_vec++; if (period_cnt !== 16'd256) begin n_err++; $display("FAIL rmid_after_period: got %0d want 256", period_cnt); end
      end
      pwm_in = (i < 64) || (i >= 256 && i < 320) || (i >= 512 && i < 576) || (i >= 768);
      meas_ready = 1'b0;
      rst = (i == 356);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 370; i++) begin
      @(negedge clk);
      if (i == 358) begin
        n_vec++; if (meas_valid !== 1'b1) begin n_err++; $display("FAIL b2b_old_valid: got %b want 1", meas_valid); end
        n_vec++; if (high_cnt !== 16'd64) begin n_err++; $display("FAIL b2b_old_high: got %0d want 64", high_cnt); end
      end
      if (i == 359 || i == 365) begin
        n_vec++; if (meas_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid@%0d: got %b want 1", i, meas_valid); end
        n_vec++; if (high_cnt !== 16'd30) begin n_err++; $display("FAIL b2b_high@%0d: got %0d want 30", i, high_cnt); end
        n_vec++; if (period_cnt !== 16'd100) begin n_err++; $display("FAIL b2b_period@%0d: got %0d want 100", i, period_cnt); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun@%0d: got %b want 0", i, overrun); end
      end
      pwm_in = (i < 64) || (i >= 256 && i < 286) || (i >= 356 && i < 360);
      meas_ready = (i == 358);
    end
  endtask

  initial begin
    rst = 1'b1;
    pwm_in = 1'b0;
    meas_ready = 1'b0;
    test_reset();
    test_pwm_64_256();
    test_narrow_pulse();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
